gcm_tag_verify: RTL and testbench
=================================

Name: gcm_tag_verify

Overview:
- Receive-side counterpart of gcm_aes.
- Recomputes the GCM authentication tag over incoming AAD and ciphertext blocks, using a GF(2^128) GHASH multiplier that is iterated over several cycles.
- Compares the result against the received tag and flags pass/fail.
- H = E(K,0^128) and E(K,J0) are supplied by the existing AES core; this block contains no AES logic.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits processed per clock. Legal values: 1, 2, 4, 8. A multiply takes MULT_CYC = 128/BITS_PER_CYCLE cycles.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; sampled only when o_busy=0.
- i_h  in  128  hash subkey H; latched on i_start.
- i_ek_j0  in  128  E(K,J0); latched on i_start.
- i_tag  in  128  received tag; latched on i_start.
- i_aad_size  in  64  AAD length in bits; latched on i_start.
- i_ct_size  in  64  ciphertext length in bits; latched on i_start.
- i_block_valid  in  1  input block valid.
- i_block  in  128  AAD/ciphertext block; bits [127:120] are the first byte.
- o_block_ready  out  1  block accepted when i_block_valid & o_block_ready.
- o_busy  out  1  high from the cycle after i_start until o_done.
- o_done  out  1  one-cycle pulse when the result is valid.
- o_tag_ok  out  1  1 when the computed tag equals i_tag; held until the next i_start or rst.
- o_computed_tag  out  128  GHASH ^ E(K,J0); held until the next i_start or rst.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; Y=0.
- Block counts: NA = ceil(aad_size/128), NC = ceil(ct_size/128), both using the latched sizes. All AAD blocks are presented first, then all ciphertext blocks.
- Partial blocks: in the last AAD block and the last CT block, bits beyond the size are forced to 0 internally. Caller padding is ignored. The mask is computed per bit, e.g. size mod 128 = 120 keeps bits [127:8].
- FSM states: IDLE, LOAD, MULT, LEN, FINAL.
- IDLE:
  - On i_start: latch all i_* values, Y<=0, clear o_tag_ok and o_computed_tag.
  - Next state is LOAD if NA+NC>0, else LEN.
- LOAD:
  - o_block_ready=1.
  - On handshake: Y <= Y ^ masked block, then go to MULT.
  - o_block_ready=0 in every other state.
- MULT:
  - Computes Y <= Y·H using the NIST right-shift algorithm with R = 0xE1 || 0^120. Y bit 127 is GCM bit 0.
  - Runs MULT_CYC cycles, with a counter wrapping at MULT_CYC-1.
  - Exit: to LOAD if blocks remain, to LEN after the last data block, to FINAL after the length block.
- LEN: Y <= Y ^ {aad_size, ct_size}, then go to MULT.
- FINAL:
  - o_computed_tag <= Y ^ ek_j0.
  - o_tag_ok <= (Y ^ ek_j0) == tag.
  - o_done=1 for this cycle; o_busy falls the same cycle; return to IDLE.
- Latency:
  - Each data block: 1 accept cycle + MULT_CYC cycles.
  - Total from i_start to o_done: (NA+NC)·(MULT_CYC+1) + MULT_CYC + 3 cycles when the source holds i_block_valid high.
- Boundary conditions:
  - i_start while o_busy: ignored.
  - i_block_valid outside LOAD: ignored; no data is lost because ready is low.
  - Sizes of 0 for AAD, CT or both are legal. With both 0, GHASH=0 and the tag equals E(K,J0).
  - rst in any state: IDLE and reset values on the next edge, including mid-MULT. A subsequent i_start runs cleanly.
  - i_start in the same cycle as o_done: ignored (o_busy is still 1 at the sample).

Test Plan:
1. Empty message:
   - Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e, ek_j0=58e2fccefa7e3061367f1d57a4e7455a, sizes 0/0, tag=58e2fccefa7e3061367f1d57a4e7455a.
   - Required: no ready; o_done after MULT_CYC+3 cycles; o_tag_ok=1; o_computed_tag=58e2…455a.
2. One ciphertext block:
   - Stimulus: same H and ek_j0; ct_size=128, aad_size=0; block 0388dace60b6a392f328c2b971b2fe78; tag ab6e47d42cec13bdf53a67b21257bddf.
   - Required: o_tag_ok=1; o_computed_tag=ab6e…bddf; o_done at 2·MULT_CYC+4.
3. Corrupted tag:
   - Stimulus: as case 2 with tag bit 0 flipped.
   - Required: o_tag_ok=0; o_computed_tag still ab6e47d42cec13bdf53a67b21257bddf.
4. Masking:
   - Stimulus: ct_size=120 with block 0388…fe78, then rerun with block 0388…fe00.
   - Required: identical o_computed_tag both runs; i_block_valid held low 5 cycles before the handshake changes only the latency.
5. Reset and restart:
   - Stimulus: assert rst mid-MULT of case 2.
   - Required: next cycle all outputs 0; rerunning case 2 gives o_tag_ok=1.
   - Also: an i_start pulsed mid-run is ignored, with the result unchanged.
6. BITS_PER_CYCLE=8:
   - Stimulus: case 2.
   - Required: same tag; o_done at cycle 36.

Source files
------------

// File: rtl/gcm_tag_verify.sv
`default_nettype none
// ============================================================================
// gcm_tag_verify : GHASH over AAD/CT blocks, tag recompute and compare
// Revision 1.0
// ============================================================================
module gcm_tag_verify #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [127:0] i_h,
    input  logic [127:0] i_ek_j0,
    input  logic [127:0] i_tag,
    input  logic [63:0]  i_aad_size,
    input  logic [63:0]  i_ct_size,
    input  logic         i_block_valid,
    input  logic [127:0] i_block,
    output logic         o_block_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_tag_ok,
    output logic [127:0] o_computed_tag
);

    localparam int MULT_CYC = 128 / BITS_PER_CYCLE;
    localparam int CNT_W    = $clog2(MULT_CYC);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MULT  = 3'd2;
    localparam logic [2:0] S_LEN   = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;

    localparam logic [127:0] GF_R = {8'hE1, 120'h0};
    localparam logic [127:0] ONES = {128{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [127:0]     h_q, ek_j0_q, tag_q;
    logic [63:0]      aad_size_q, ct_size_q;
    logic [57:0]      aad_left_q, ct_left_q;
    logic             len_done_q;
    logic [127:0]     y_q, z_q, v_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tag_ok_q;
    logic [127:0]     comp_tag_q;

    logic [127:0]     z_d, v_d, x_d;
    logic [57:0]      w_na, w_nc;
    logic             w_in_aad, w_last, w_hs, w_mult_last, w_more;
    logic [6:0]       w_rem;
    logic [127:0]     w_mask, w_final_tag;

    assign w_na        = {1'b0, i_aad_size[63:7]} + {57'd0, |i_aad_size[6:0]};
    assign w_nc        = {1'b0, i_ct_size[63:7]}  + {57'd0, |i_ct_size[6:0]};
    assign w_in_aad    = (aad_left_q != 58'd0);
    assign w_last      = w_in_aad ? (aad_left_q == 58'd1) : (ct_left_q == 58'd1);
    assign w_rem       = w_in_aad ? aad_size_q[6:0] : ct_size_q[6:0];
    // Only the final block of each section can be partial; keep its top w_rem bits.
    assign w_mask      = (w_last && (w_rem != 7'd0)) ? ~(ONES >> w_rem) : ONES;
    assign w_hs        = i_block_valid & o_block_ready;
    assign w_mult_last = (cnt_q == CNT_W'(MULT_CYC - 1));
    assign w_more      = ((aad_left_q | ct_left_q) != 58'd0);
    assign w_final_tag = y_q ^ ek_j0_q;

    // Multiplier operand x is consumed MSB-first (GCM bit 0 first) from y_q.
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        x_d = y_q;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (x_d[127]) begin
                z_d = z_d ^ v_d;
            end
            v_d = v_d[0] ? ((v_d >> 1) ^ GF_R) : (v_d >> 1);
            x_d = x_d << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = ((w_na | w_nc) != 58'd0) ? S_LOAD : S_LEN;
            S_LOAD:  if (w_hs) state_d = S_MULT;
            S_MULT:  if (w_mult_last) state_d = len_done_q ? S_FINAL : (w_more ? S_LOAD : S_LEN);
            S_LEN:   state_d = S_MULT;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_block_ready  = (state_q == S_LOAD);
        o_busy         = (state_q != S_IDLE);
        o_done         = (state_q == S_FINAL);
        o_computed_tag = (state_q == S_FINAL) ? w_final_tag : comp_tag_q;
        o_tag_ok       = (state_q == S_FINAL) ? (w_final_tag == tag_q) : tag_ok_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q        <= '0;
            ek_j0_q    <= '0;
            tag_q      <= '0;
            aad_size_q <= '0;
            ct_size_q  <= '0;
            aad_left_q <= '0;
            ct_left_q  <= '0;
            len_done_q <= 1'b0;
            y_q        <= '0;
            z_q        <= '0;
            v_q        <= '0;
            cnt_q      <= '0;
            tag_ok_q   <= 1'b0;
            comp_tag_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        h_q        <= i_h;
                        ek_j0_q    <= i_ek_j0;
                        tag_q      <= i_tag;
                        aad_size_q <= i_aad_size;
                        ct_size_q  <= i_ct_size;
                        aad_left_q <= w_na;
                        ct_left_q  <= w_nc;
                        len_done_q <= 1'b0;
                        y_q        <= '0;
                        tag_ok_q   <= 1'b0;
                        comp_tag_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        y_q   <= y_q ^ (i_block & w_mask);
                        z_q   <= '0;
                        v_q   <= h_q;
                        cnt_q <= '0;
                        if (w_in_aad) begin
                            aad_left_q <= aad_left_q - 58'd1;
                        end else begin
                            ct_left_q <= ct_left_q - 58'd1;
                        end
                    end
                end
                S_MULT: begin
                    z_q   <= z_d;
                    v_q   <= v_d;
                    y_q   <= w_mult_last ? z_d : x_d;
                    cnt_q <= w_mult_last ? '0 : cnt_q + CNT_W'(1);
                end
                S_LEN: begin
                    y_q        <= y_q ^ {aad_size_q, ct_size_q};
                    z_q        <= '0;
                    v_q        <= h_q;
                    cnt_q      <= '0;
                    len_done_q <= 1'b1;
                end
                S_FINAL: begin
                    comp_tag_q <= w_final_tag;
                    tag_ok_q   <= (w_final_tag == tag_q);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcm_tag_verify.sv
`default_nettype none
// ============================================================================
// tb_gcm_tag_verify : directed NIST vectors plus randomized runs vs GCM model
// Revision 1.0
// ============================================================================
module tb_gcm_tag_verify;

    localparam logic [127:0] H0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EK0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] CT0 = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T0  = 128'hab6e47d42cec13bdf53a67b21257bddf;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, valid;
    logic [127:0] h_in, ek_in, tag_in, blk_in;
    logic [63:0]  asz_in, csz_in;
    bit           sel8;

    logic         rdy_a, busy_a, done_a, ok_a, rdy_b, busy_b, done_b, ok_b;
    logic [127:0] ct_a, ct_b;
    logic         w_rdy, w_busy, w_done, w_ok;
    logic [127:0] w_ctag;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] blk_q[$];

    always #5 clk = ~clk;

    gcm_tag_verify #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start & ~sel8), .i_h(h_in), .i_ek_j0(ek_in),
        .i_tag(tag_in), .i_aad_size(asz_in), .i_ct_size(csz_in),
        .i_block_valid(valid & ~sel8), .i_block(blk_in), .o_block_ready(rdy_a),
        .o_busy(busy_a), .o_done(done_a), .o_tag_ok(ok_a), .o_computed_tag(ct_a));

    gcm_tag_verify #(.BITS_PER_CYCLE(8)) u_dut8 (
        .clk(clk), .rst(rst), .i_start(start & sel8), .i_h(h_in), .i_ek_j0(ek_in),
        .i_tag(tag_in), .i_aad_size(asz_in), .i_ct_size(csz_in),
        .i_block_valid(valid & sel8), .i_block(blk_in), .o_block_ready(rdy_b),
        .o_busy(busy_b), .o_done(done_b), .o_tag_ok(ok_b), .o_computed_tag(ct_b));

    assign w_rdy  = sel8 ? rdy_b  : rdy_a;
    assign w_busy = sel8 ? busy_b : busy_a;
    assign w_done = sel8 ? done_b : done_a;
    assign w_ok   = sel8 ? ok_b   : ok_a;
    assign w_ctag = sel8 ? ct_b   : ct_a;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // GF(2^128) product, vector bit 127 = GCM bit 0.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z = '0;
        logic [127:0] v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'hE1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [127:0] ref_tag(input logic [127:0] h, input logic [127:0] ek,
                                             input logic [63:0] asz, input logic [63:0] csz);
        int na = int'((asz + 127) / 128);
        int nc = int'((csz + 127) / 128);
        logic [127:0] y = '0;
        logic [127:0] b;
        longint keep;
        for (int i = 0; i < na + nc; i++) begin
            b = blk_q[i];
            keep = (i < na) ? longint'(asz) - 128 * i : longint'(csz) - 128 * (i - na);
            for (int k = 0; k < 128; k++) if (k >= keep) b[127-k] = 1'b0;
            y = gf_mul(y ^ b, h);
        end
        y = gf_mul(y ^ {asz, csz}, h);
        return y ^ ek;
    endfunction

    function automatic int mult_cyc();
        return sel8 ? 16 : 128;
    endfunction

    task automatic run_txn(input logic [127:0] h, input logic [127:0] ek, input logic [127:0] tg,
                           input logic [63:0] asz, input logic [63:0] csz,
                           input int first_stall, input int max_stall, input bit midstart,
                           output int cyc, output int stalls, output int rdy_cyc,
                           output logic ok, output logic [127:0] ctag,
                           output logic busy_after, output bit to);
        int idx = 0;
        int sl = first_stall;
        bit hs = 1'b0;
        @(negedge clk);
        h_in = h; ek_in = ek; tag_in = tg; asz_in = asz; csz_in = csz;
        start = 1'b1; valid = $urandom_range(0, 1); blk_in = {4{$urandom}};
        cyc = 1; stalls = 0; rdy_cyc = 0; ok = 1'b0; ctag = '0; busy_after = 1'b1; to = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            if (hs) begin
                idx++;
                sl = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0; h_in = h; tag_in = tg;
            if (w_done) begin
                ok = w_ok; ctag = w_ctag; to = 1'b0;
                break;
            end
            if (midstart && cyc == 6) begin
                start = 1'b1; h_in = ~h; tag_in = ~tg;
            end
            hs = 1'b0;
            if (w_rdy) begin
                rdy_cyc++;
                if (sl > 0) begin
                    valid = 1'b0; sl--; stalls++;
                end else if (idx < blk_q.size()) begin
                    valid = 1'b1; blk_in = blk_q[idx]; hs = 1'b1;
                end else begin
                    valid = 1'b0;
                end
            end else begin
                valid = $urandom_range(0, 1); blk_in = {4{$urandom}};
            end
        end
        valid = 1'b0;
        if (!to) begin
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            busy_after = w_busy;
        end
        start = 1'b0;
    endtask

    int cyc, stalls, rdy_cyc;
    logic ok, busy_after;
    logic [127:0] ctag, ctag_a, exp_t, tg;
    bit to, good;
    int nblk, m;
    logic [63:0] asz, csz;
    logic [127:0] hh, ee;

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; sel8 = 1'b0;
        h_in = '0; ek_in = '0; tag_in = '0; blk_in = '0; asz_in = '0; csz_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ctrl", {125'd0, w_busy, w_done, w_rdy}, '0);
        check("reset_tag", {w_ctag[126:0], w_ok}, '0);

        // Empty message
        blk_q = {};
        run_txn(H0, EK0, EK0, 64'd0, 64'd0, 0, 0, 1'b0, cyc, stalls, rdy_cyc, ok, ctag, busy_after, to);
        check("empty_to", to, 0);
        check("empty_ok", ok, 1);
        check("empty_tag", ctag, EK0);
        check("empty_lat", cyc, mult_cyc() + 3);
        check("empty_rdy", rdy_cyc, 0);
        check("start_at_done", busy_after, 0);

        // One ciphertext block
        blk_q = {CT0};
        run_txn(H0, EK0, T0, 64'd0, 64'd128, 0, 0, 1'b0, cyc, stalls, rdy_cyc, ok, ctag, busy_after, to);
        check("ct1_ok", ok, 1);
        check("ct1_tag", ctag, T0);
        check("ct1_lat", cyc, 2 * mult_cyc() + 4);
        check("ct1_held", w_ctag, T0);

        // Corrupted tag
        run_txn(H0, EK0, T0 ^ 128'd1, 64'd0, 64'd128, 0, 0, 1'b0, cyc, stalls, rdy_cyc, ok, ctag, busy_after, to);
        check("bad_ok", ok, 0);
        check("bad_tag", ctag, T0);
        check("bad_held_ok", w_ok, 0);

        // Masking of a partial last block, with a 5-cycle source stall
        blk_q = {CT0};
        run_txn(H0, EK0, T0, 64'd0, 64'd120, 0, 0, 1'b0, cyc, stalls, rdy_cyc, ok, ctag_a, busy_after, to);
        check("mask_model", ctag_a, ref_tag(H0, EK0, 64'd0, 64'd120));
        blk_q = {{CT0[127:8], 8'h00}};
        run_txn(H0, EK0, T0, 64'd0, 64'd120, 5, 0, 1'b0, cyc, stalls, rdy_cyc, ok, ctag, busy_after, to);
        check("mask_same", ctag, ctag_a);
        check("mask_lat", cyc, 2 * mult_cyc() + 4 + 5);

        // Reset in the middle of a multiply
        blk_q = {CT0};
        @(negedge clk);
        h_in = H0; ek_in = EK0; tag_in = T0; asz_in = 64'd0; csz_in = 64'd128; start = 1'b1;
        @(negedge clk);
        start = 1'b0; valid = 1'b1; blk_in = CT0;
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", w_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ctrl", {125'd0, w_busy, w_done, w_rdy}, '0);
        check("rst_tag", {w_ctag[126:0], w_ok}, '0);
        run_txn(H0, EK0, T0, 64'd0, 64'd128, 0, 0, 1'b1, cyc, stalls, rdy_cyc, ok, ctag, busy_after, to);
        check("restart_ok", ok, 1);
        check("restart_tag", ctag, T0);
        check("restart_lat", cyc, 2 * mult_cyc() + 4);

        // Randomized runs on both multiplier widths
        for (int r = 0; r < 16; r++) begin
            sel8 = (r >= 10);
            m = mult_cyc();
            asz = 64'($urandom_range(0, 300));
            csz = 64'($urandom_range(0, 300));
            if (r == 3) begin asz = 64'd0; csz = 64'd0; end
            nblk = int'((asz + 127) / 128 + (csz + 127) / 128);
            blk_q = {};
            for (int i = 0; i < nblk; i++) blk_q.push_back({$urandom, $urandom, $urandom, $urandom});
            hh = {$urandom, $urandom, $urandom, $urandom};
            ee = {$urandom, $urandom, $urandom, $urandom};
            exp_t = ref_tag(hh, ee, asz, csz);
            good = $urandom_range(0, 1);
            tg = good ? exp_t : exp_t ^ (128'd1 << $urandom_range(0, 127));
            run_txn(hh, ee, tg, asz, csz, 0, 3, 1'b0, cyc, stalls, rdy_cyc, ok, ctag, busy_after, to);
            check($sformatf("rnd%0d_to", r), to, 0);
            check($sformatf("rnd%0d_tag", r), ctag, exp_t);
            check($sformatf("rnd%0d_ok", r), ok, good);
            check($sformatf("rnd%0d_lat", r), cyc, nblk * (m + 1) + m + 3 + stalls);
        end

        // 8 bits per cycle on the NIST one-block vector
        sel8 = 1'b1;
        blk_q = {CT0};
        run_txn(H0, EK0, T0, 64'd0, 64'd128, 0, 0, 1'b0, cyc, stalls, rdy_cyc, ok, ctag, busy_after, to);
        check("bpc8_tag", ctag, T0);
        check("bpc8_ok", ok, 1);
        check("bpc8_lat", cyc, 36);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
